// File: rtl/led_matrix_scan_controller.sv
// Double-buffered 8x8 LED matrix scan controller with blanked row multiplexing.
// Define LED_MATRIX_PWM_EN to add 16-slot per-row brightness control.
module led_matrix_scan_controller #(
    parameter int CLKS_PER_ROW   = 1024,
    parameter int BLANK_CLKS     = 16,
    parameter int ROW_ACTIVE_LOW = 1,
    parameter int COL_ACTIVE_LOW = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        writeEnable,
    input  logic        readEnable,
    input  logic [1:0]  address,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        success,
    output logic [7:0]  ledMatrixRow,
    output logic [7:0]  ledMatrixColumn,
    output logic        frameDone
);

    localparam int CNT_MAX = (CLKS_PER_ROW > BLANK_CLKS) ? CLKS_PER_ROW : BLANK_CLKS;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] DRIVE_LAST = CW'(CLKS_PER_ROW - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CLKS - 1);

    localparam logic [7:0] ROW_OFF = (ROW_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [7:0] COL_OFF = (COL_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    typedef enum logic {
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [2:0]      row;
    logic [2:0]      row_n;
    logic            frame_end;
    logic            drive;

    logic [7:0]      fb [2][8];
    logic            front_sel;
    logic            back_sel;
    logic            swap_pending;
    logic            ctrl_wr;
    logic            col_on;
    logic [3:0]      bright_rd;
    logic [31:0]     ctrl_rd;
    logic [31:0]     status;
    logic [31:0]     rd_data;

    assign drive    = (state == S_DRIVE);
    assign back_sel = ~front_sel;
    assign ctrl_wr  = writeEnable && (address == 2'd2);

    // Scan sequencer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_BLANK;
            cnt   <= '0;
            row   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            row   <= row_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        row_n     = row;
        frame_end = 1'b0;
        unique case (state)
            S_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_n = S_DRIVE;
                    cnt_n   = '0;
                end
            end
            S_DRIVE: begin
                if (cnt == DRIVE_LAST) begin
                    state_n   = S_BLANK;
                    cnt_n     = '0;
                    row_n     = row + 3'd1;
                    frame_end = (row == 3'd7);
                end
            end
        endcase
    end

    // A request landing on the frame edge survives: set beats clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            if (frame_end && swap_pending) begin
                front_sel <= ~front_sel;
            end
            if (ctrl_wr && dataIn[0]) begin
                swap_pending <= 1'b1;
            end else if (frame_end) begin
                swap_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 8; j++) begin
                    fb[i][j] <= 8'd0;
                end
            end
        end else if (writeEnable && !address[1]) begin
            for (int k = 0; k < 4; k++) begin
                fb[back_sel][{address[0], k[1:0]}] <= dataIn[8*k +: 8];
            end
        end
    end

`ifdef LED_MATRIX_PWM_EN
    localparam int SLOT_CLKS = CLKS_PER_ROW / 16;

    logic [3:0] bright;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bright <= 4'hF;
        end else if (ctrl_wr) begin
            bright <= dataIn[11:8];
        end
    end

    // Lit while the drive count is inside the first B slots
    assign col_on    = (32'(bright) * 32'(SLOT_CLKS)) > 32'(cnt);
    assign bright_rd = bright;
    assign ctrl_rd   = {20'd0, bright, 8'd0};
`else
    assign col_on    = 1'b1;
    assign bright_rd = 4'd0;
    assign ctrl_rd   = 32'd0;
`endif

    assign status = {20'd0, bright_rd, drive, row, 2'b00, front_sel, swap_pending};

    always_comb begin
        rd_data = 32'd0;
        unique case (address)
            2'd0: rd_data = {fb[back_sel][3], fb[back_sel][2],
                             fb[back_sel][1], fb[back_sel][0]};
            2'd1: rd_data = {fb[back_sel][7], fb[back_sel][6],
                             fb[back_sel][5], fb[back_sel][4]};
            2'd2: rd_data = ctrl_rd;
            2'd3: rd_data = status;
        endcase
    end

    // A colliding read is dropped; the write still gets its single ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dataOut <= 32'd0;
            success <= 1'b0;
        end else begin
            success <= writeEnable || readEnable;
            if (readEnable && !writeEnable) begin
                dataOut <= rd_data;
            end
        end
    end

    assign ledMatrixRow    = (drive ? (8'd1 << row) : 8'd0) ^ ROW_OFF;
    assign ledMatrixColumn = ((drive && col_on) ? fb[front_sel][row] : 8'd0) ^ COL_OFF;
    assign frameDone       = frame_end;

endmodule
